// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-bank access controller.
// Widths here set the layout of the buffered request word.
package spi_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] RO_ADDR = '0;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RWAIT
  } ctrl_state_t;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } spi_req_t;

endpackage

// File: rtl/spi_req_fifo.sv
// Synchronous request FIFO of spi_req_t; head is visible combinationally, push to pop is one cycle.
// Push while full and pop while empty are ignored; full does not see a same-cycle pop.
module spi_req_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  spi_req_t push_dat,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output spi_req_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  spi_req_t       mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           do_push;
  logic           do_pop;

  // The extra pointer bit separates full from empty when the index bits match.
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= push_dat;
        wr_ptr                 <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Arbitrates the register bank between buffered SPI requests and one on-chip writer, round-robin.
// Write strobe 2 cycles after fe_valid, read data 4; fe_ready drops when the buffer is full and excess requests set overflow.
module spi_reg_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = spi_pkg::ADDR_W,
  parameter int DATA_W     = spi_pkg::DATA_W
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              fe_valid,
  input  logic              fe_is_write,
  input  logic [ADDR_W-1:0] fe_addr,
  input  logic [DATA_W-1:0] fe_wdata,
  output logic              fe_ready,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [DATA_W-1:0] int_wdata,
  output logic              int_gnt,
  output logic              reg_we,
  output logic              reg_re,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overflow
);

  import spi_pkg::*;

  ctrl_state_t state;
  logic        last_int;
  logic        full;
  logic        empty;
  logic        int_pick;
  logic        spi_pick;
  spi_req_t    push_dat;
  spi_req_t    head;

  assign push_dat = '{is_write: fe_is_write, addr: fe_addr, wdata: fe_wdata};
  assign fe_ready = !full;

  // With both sources pending, whoever was not served last wins.
  assign int_pick = (state == IDLE) && int_req && (empty || !last_int);
  assign spi_pick = (state == IDLE) && !empty && !int_pick;

  spi_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (spi_clk),
    .rst     (rst),
    .push    (fe_valid),
    .push_dat(push_dat),
    .pop     (spi_pick),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state     <= IDLE;
      last_int  <= 1'b1;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      int_gnt   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      int_gnt  <= 1'b0;
      rd_valid <= 1'b0;
      if (fe_valid && full) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (int_pick) begin
            state     <= WR;
            last_int  <= 1'b1;
            reg_we    <= 1'b1;
            int_gnt   <= 1'b1;
            reg_addr  <= int_addr;
            reg_wdata <= int_wdata;
          end else if (spi_pick) begin
            last_int <= 1'b0;
            if (head.is_write) begin
              state <= WR;
              // The chip ID register is read-only from SPI: the slot is spent without a strobe.
              if (head.addr != RO_ADDR) begin
                reg_we    <= 1'b1;
                reg_addr  <= head.addr;
                reg_wdata <= head.wdata;
              end
            end else begin
              state    <= RD;
              reg_re   <= 1'b1;
              reg_addr <= head.addr;
            end
          end
        end
        WR:      state <= IDLE;
        RD:      state <= RWAIT;
        RWAIT: begin
          rd_data  <= reg_rdata;
          rd_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model (request queue, busy countdown, round-robin flag).
module tb_spi_reg_ctrl;

  localparam int DEPTH = 4;

  logic       spi_clk = 1'b0;
  logic       rst = 1'b1;
  logic       fe_valid = 1'b0;
  logic       fe_is_write = 1'b0;
  logic [6:0] fe_addr = '0;
  logic [7:0] fe_wdata = '0;
  logic       fe_ready;
  logic       int_req = 1'b0;
  logic [6:0] int_addr = '0;
  logic [7:0] int_wdata = '0;
  logic       int_gnt;
  logic       reg_we;
  logic       reg_re;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       overflow;

  always #5 spi_clk = ~spi_clk;

  spi_reg_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (7),
    .DATA_W    (8)
  ) dut (
    .spi_clk    (spi_clk),
    .rst        (rst),
    .fe_valid   (fe_valid),
    .fe_is_write(fe_is_write),
    .fe_addr    (fe_addr),
    .fe_wdata   (fe_wdata),
    .fe_ready   (fe_ready),
    .int_req    (int_req),
    .int_addr   (int_addr),
    .int_wdata  (int_wdata),
    .int_gnt    (int_gnt),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .overflow   (overflow)
  );

  // Register bank: unwritten locations return their power-up value.
  logic [7:0] init_val [128];
  logic [7:0] bank [128];
  bit         written [128];

  always @(posedge spi_clk) begin
    if (reg_we) begin
      bank[reg_addr]    <= reg_wdata;
      written[reg_addr] <= 1'b1;
    end
    if (reg_re) reg_rdata <= written[reg_addr] ? bank[reg_addr] : init_val[reg_addr];
  end

  typedef struct { bit w; logic [6:0] a; logic [7:0] d; } req_t;
  typedef struct { int cyc; bit we; bit gnt; logic [6:0] a; logic [7:0] d; } ev_t;
  typedef struct { int cyc; logic [7:0] d; } rv_t;

  req_t       m_q[$];
  ev_t        ev_q[$];
  rv_t        rv_q[$];
  logic [7:0] m_mem [128];
  int         m_busy = 0;
  bit         m_last_int = 1'b1;
  bit         m_ovf = 1'b0;

  int cyc = 0;
  int int_release = 0;
  int n_chk = 0;
  int n_fail = 0;

  int         n_we = 0, n_re = 0, n_rv = 0;
  int         last_we_cyc = -1000, last_re_cyc = -1000, last_rv_cyc = -1000;
  logic [6:0] last_we_addr;
  logic [7:0] last_we_dat, last_rv_dat;
  bit         last_we_gnt;
  bit         obs_fe_ready;
  logic [7:0] we_log[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One cycle of the reference: arbitration outcome in an idle slot, then the push decision.
  task automatic model_step();
    int   sz0;
    req_t r;
    if (rst) begin
      m_q.delete();
      m_busy     = 0;
      m_last_int = 1'b1;
      m_ovf      = 1'b0;
      while (ev_q.size() > 0 && ev_q[$].cyc > cyc) void'(ev_q.pop_back());
      while (rv_q.size() > 0 && rv_q[$].cyc > cyc) void'(rv_q.pop_back());
      return;
    end
    sz0 = m_q.size();
    if (m_busy == 0) begin
      if (int_req && (sz0 == 0 || !m_last_int)) begin
        ev_q.push_back('{cyc + 1, 1'b1, 1'b1, int_addr, int_wdata});
        m_busy      = 1;
        m_last_int  = 1'b1;
        int_release = cyc + 2;
      end else if (sz0 > 0) begin
        r          = m_q.pop_front();
        m_last_int = 1'b0;
        if (r.w) begin
          m_busy = 1;
          if (r.a != 7'd0) ev_q.push_back('{cyc + 1, 1'b1, 1'b0, r.a, r.d});
        end else begin
          m_busy = 2;
          ev_q.push_back('{cyc + 1, 1'b0, 1'b0, r.a, 8'h00});
          rv_q.push_back('{cyc + 3, m_mem[r.a]});
        end
      end
    end else begin
      m_busy--;
    end
    if (fe_valid) begin
      if (sz0 == DEPTH) m_ovf = 1'b1;
      else m_q.push_back('{fe_is_write, fe_addr, fe_wdata});
    end
  endtask

  task automatic check_outputs(input bit e_rdy, input bit e_ovf);
    bit         e_we = 1'b0, e_re = 1'b0, e_gnt = 1'b0, e_rv = 1'b0;
    logic [6:0] ea = '0;
    logic [7:0] ed = '0, erd = '0;
    ev_t        e;
    rv_t        v;
    if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
      e     = ev_q.pop_front();
      e_we  = e.we;
      e_re  = !e.we;
      e_gnt = e.gnt;
      ea    = e.a;
      ed    = e.d;
    end
    if (rv_q.size() > 0 && rv_q[0].cyc == cyc) begin
      v    = rv_q.pop_front();
      e_rv = 1'b1;
      erd  = v.d;
    end
    check_eq("reg_we", reg_we, e_we);
    check_eq("reg_re", reg_re, e_re);
    check_eq("int_gnt", int_gnt, e_gnt);
    if (e_we || e_re) check_eq("reg_addr", reg_addr, ea);
    if (e_we) begin
      check_eq("reg_wdata", reg_wdata, ed);
      m_mem[ea] = ed;
    end
    check_eq("rd_valid", rd_valid, e_rv);
    if (e_rv) check_eq("rd_data", rd_data, erd);
    check_eq("fe_ready", fe_ready, e_rdy);
    check_eq("overflow", overflow, e_ovf);

    obs_fe_ready = fe_ready;
    if (reg_we) begin
      n_we++;
      last_we_cyc  = cyc;
      last_we_addr = reg_addr;
      last_we_dat  = reg_wdata;
      last_we_gnt  = int_gnt;
      we_log.push_back({int_gnt, reg_addr});
    end
    if (reg_re) begin
      n_re++;
      last_re_cyc = cyc;
    end
    if (rd_valid) begin
      n_rv++;
      last_rv_cyc = cyc;
      last_rv_dat = rd_data;
    end
  endtask

  // Drives one cycle; the on-chip requester holds its request until the cycle after its grant.
  task automatic tick(input bit fv, input bit w, input logic [6:0] a, input logic [7:0] d,
                      input bit inew, input logic [6:0] ia, input logic [7:0] id, input bit r);
    bit e_rdy, e_ovf;
    if (int_req && cyc >= int_release) int_req = 1'b0;
    if (inew && !int_req) begin
      int_req     = 1'b1;
      int_addr    = ia;
      int_wdata   = id;
      int_release = 32'h7fff_ffff;
    end
    fe_valid    = fv;
    fe_is_write = w;
    fe_addr     = a;
    fe_wdata    = d;
    rst         = r;
    e_rdy = (m_q.size() < DEPTH);
    e_ovf = m_ovf;
    model_step();
    @(negedge spi_clk);
    check_outputs(e_rdy, e_ovf);
    @(posedge spi_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1);
  endtask

  initial begin
    int         n0, nrv0, nre0, nwe0;
    logic [7:0] exp_order [4];
    logic [7:0] v8;

    for (int i = 0; i < 128; i++) begin
      v8          = 8'($urandom);
      init_val[i] = v8;
      m_mem[i]    = v8;
    end
    init_val[5] = 8'h3C;
    m_mem[5]    = 8'h3C;

    repeat (3) @(posedge spi_clk);
    #1;
    do_reset();
    check_eq("rst_reg_we", reg_we, 0);
    check_eq("rst_reg_re", reg_re, 0);
    check_eq("rst_int_gnt", int_gnt, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_reg_addr", reg_addr, 0);
    check_eq("rst_reg_wdata", reg_wdata, 0);
    check_eq("rst_fe_ready", fe_ready, 1);
    check_eq("rst_overflow", overflow, 0);

    // SPI write latency and fields
    n0 = cyc;
    tick(1'b1, 1'b1, 7'h12, 8'hA5, 1'b0, 7'h00, 8'h00, 1'b0);
    idle(4);
    check_eq("wr_latency", last_we_cyc - n0, 2);
    check_eq("wr_addr", last_we_addr, 8'h12);
    check_eq("wr_data", last_we_dat, 8'hA5);

    // SPI readback
    n0 = cyc;
    tick(1'b1, 1'b0, 7'h05, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    idle(6);
    check_eq("rd_re_latency", last_re_cyc - n0, 2);
    check_eq("rd_valid_latency", last_rv_cyc - n0, 4);
    check_eq("rd_data_val", last_rv_dat, 8'h3C);

    // Contention: SPI, INT, SPI, SPI
    do_reset();
    we_log.delete();
    tick(1'b1, 1'b1, 7'h21, 8'h01, 1'b0, 7'h00, 8'h00, 1'b0);
    tick(1'b1, 1'b1, 7'h22, 8'h02, 1'b1, 7'h40, 8'h11, 1'b0);
    tick(1'b1, 1'b1, 7'h23, 8'h03, 1'b0, 7'h00, 8'h00, 1'b0);
    idle(10);
    exp_order = '{8'h21, 8'hC0, 8'h22, 8'h23};
    check_eq("rr_count", we_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq("rr_order", (i < we_log.size()) ? we_log[i] : 8'hFF, exp_order[i]);

    // Overflow: FSM kept busy by a read then an internal write
    do_reset();
    nrv0 = n_rv;
    tick(1'b1, 1'b0, 7'h10, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 7'h11, 8'h00, 1'b1, 7'h41, 8'h22, 1'b0);
    tick(1'b1, 1'b0, 7'h12, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 7'h13, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 7'h14, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 7'h15, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    check_eq("ovf_full_fe_ready", obs_fe_ready, 0);
    idle(30);
    check_eq("ovf_sticky", overflow, 1);
    check_eq("ovf_reads_served", n_rv - nrv0, 5);
    do_reset();
    check_eq("ovf_cleared", overflow, 0);
    check_eq("ovf_fe_ready", fe_ready, 1);

    // Write protection of address 0
    idle(2);
    nwe0 = n_we;
    n0   = cyc;
    tick(1'b1, 1'b1, 7'h00, 8'hEE, 1'b0, 7'h00, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 7'h05, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    idle(6);
    check_eq("ro_no_we", n_we - nwe0, 0);
    check_eq("ro_popped", last_re_cyc - (n0 + 1), 3);
    n0 = cyc;
    tick(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h00, 8'h5A, 1'b0);
    idle(4);
    check_eq("int_ro_latency", last_we_cyc - n0, 1);
    check_eq("int_ro_addr", last_we_addr, 0);
    check_eq("int_ro_data", last_we_dat, 8'h5A);
    check_eq("int_ro_gnt", last_we_gnt, 1);

    // Reset during RD with two requests queued
    do_reset();
    tick(1'b1, 1'b0, 7'h05, 8'h00, 1'b1, 7'h30, 8'h33, 1'b0);
    tick(1'b1, 1'b0, 7'h06, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 7'h07, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
    check_eq("mid_in_rd", reg_re, 1);
    do_reset();
    nrv0 = n_rv;
    nre0 = n_re;
    n0   = cyc;
    tick(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h31, 8'h44, 1'b0);
    check_eq("mid_fe_ready", obs_fe_ready, 1);
    idle(6);
    check_eq("mid_no_rd_valid", n_rv - nrv0, 0);
    check_eq("mid_fifo_empty", n_re - nre0, 0);
    check_eq("mid_int_latency", last_we_cyc - n0, 1);
    check_eq("mid_int_gnt", last_we_gnt, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 5) == 0) ? 7'h00 : 7'($urandom_range(0, 127)), 8'($urandom),
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom_range(0, 127)), 8'($urandom),
           $urandom_range(0, 299) == 0);
    end
    idle(12);
    check_eq("drain_bank_ops", ev_q.size(), 0);
    check_eq("drain_readbacks", rv_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-bank access controller between `spi_frontend` and the chip configuration register bank. Buffers decoded SPI requests (`is_write`/`addr`/`wdata`) in a small FIFO and arbitrates the bank's single port round-robin against one on-chip requester (status/readout logic). Sequences bank writes and reads, and returns read data to the SPI serializer. Runs entirely in the `spi_clk` domain.

## Interface

Parameters:
- `FIFO_DEPTH`, 4: SPI request buffer entries (power of two, ≥2)
- `ADDR_W`, 7: register address width
- `DATA_W`, 8: register data width

Ports:
- `spi_clk` in 1: the only clock
- `rst` in 1: synchronous, active-high reset
- `fe_valid` in 1: one-cycle pulse; the frontend frame is complete and `fe_*` fields are stable
- `fe_is_write` in 1: 1 = write, 0 = read
- `fe_addr` in ADDR_W: request address
- `fe_wdata` in DATA_W: write data; ignored for reads
- `fe_ready` out 1: FIFO not full
- `int_req` in 1: on-chip write request; held until granted
- `int_addr` in ADDR_W: on-chip write address
- `int_wdata` in DATA_W: on-chip write data
- `int_gnt` out 1: one-cycle pulse; the on-chip write is performed this cycle
- `reg_we` out 1: bank write strobe
- `reg_re` out 1: bank read strobe
- `reg_addr` out ADDR_W: bank address
- `reg_wdata` out DATA_W: bank write data
- `reg_rdata` in DATA_W: bank read data; valid one cycle after `reg_re`
- `rd_data` out DATA_W: readback data to the serializer
- `rd_valid` out 1: one-cycle pulse; `rd_data` is valid
- `overflow` out 1: sticky flag; an SPI request was dropped

## Operation

- **Push.** `fe_valid && !full` pushes `{is_write, addr, wdata}`.
  - `fe_valid` while full drops the request and sets `overflow`.
  - A pop in the same cycle does not free space for that push.
  - `overflow` clears only on `rst`.
- **FSM states.** IDLE, WR, RD, RWAIT. All bank-side outputs are registered.
- **IDLE.**
  - Candidates are FIFO non-empty and `int_req`.
  - If both are pending, the source not served last wins; the pointer `last_int` updates on every grant.
  - SPI write: pop, go to WR.
  - SPI read: pop, go to RD.
  - Internal: go to WR, internal source.
- **WR.**
  - `reg_we` = 1 for one cycle with the latched addr/data.
  - For the internal source, `int_gnt` = 1 in the same cycle.
  - Then IDLE.
- **Write protection.** An SPI write to address 0 (chip ID, read-only) is popped and passes through WR with `reg_we` forced to 0. Internal writes to address 0 are allowed.
- **RD.** `reg_re` = 1 for one cycle with `reg_addr`. Then RWAIT.
- **RWAIT.** Capture `reg_rdata` into `rd_data`, then IDLE. `rd_valid` pulses in the following cycle.
- **Idle outputs.** `reg_addr`/`reg_wdata` hold their last value when not strobed. `rd_data` holds until the next read.

## Timing

- **Reset values.** All outputs are 0, `fe_ready` = 1, FIFO empty, FSM in IDLE, `last_int` = 1 (SPI wins first). A reset mid-operation discards FIFO contents and any in-flight op; no strobe is asserted in the cycle after `rst` deasserts.
- **Write latency.** `fe_valid` at cycle N with FSM in IDLE and the FIFO previously empty:
  - pop decision at N+1;
  - `reg_we` at N+2.
- **Read latency.**
  - `reg_re` at N+2.
  - RWAIT at N+3.
  - `rd_valid` at N+4.
- **Throughput.** One write per 2 cycles; one read per 3 cycles.
- **Internal request.** `int_req` sampled at cycle M in IDLE with no contention gives `int_gnt` at M+1. The requester deasserts or changes `int_*` only after the `int_gnt` cycle.
- **Exclusivity.** `reg_we` and `reg_re` are never high together. `int_gnt` implies `reg_we`.

## Structure

- **Package `spi_pkg`** holds:
  - `ADDR_W`, `DATA_W`, `RO_ADDR` = 0;
  - state enum `ctrl_state_t` {IDLE, WR, RD, RWAIT};
  - packed struct `spi_req_t` {is_write, addr, wdata}.
- **Sub-module `spi_req_fifo`.** Synchronous FIFO of `spi_req_t`, depth `FIFO_DEPTH`.
  - Ports: push, pop, full, empty, head.
  - Pointers carry one extra bit for the full/empty distinction and wrap modulo 2·depth.
- **Top module.** `spi_reg_ctrl` holds the FSM, round-robin pointer, output registers and the overflow flag.

## Test plan

- **SPI write.** fe write addr 0x12 data 0xA5 → `reg_we` pulse exactly 2 cycles after `fe_valid`, `reg_addr` = 0x12, `reg_wdata` = 0xA5.
- **SPI readback.** Bank model holds 0x3C at 0x05; fe read 0x05 → `reg_re` at +2, `rd_valid` at +4 with `rd_data` = 0x3C.
- **Contention.** `int_req` (0x40, 0x11) held while 3 SPI writes are queued → bank sees SPI, INT, SPI, SPI order. `int_gnt` coincides with the 0x40 write.
- **Overflow.** 5 back-to-back `fe_valid` while the FSM is busy and DEPTH = 4 → fifth request dropped, `fe_ready` low when full, `overflow` stays 1 until `rst`.
- **Write protection.** SPI write to 0x00 → no `reg_we` and FIFO entry consumed. Internal write to 0x00 → `reg_we` asserted.
- **Reset mid-operation.** `rst` asserted during RD with 2 entries queued → after release: no `rd_valid`, FIFO empty, `fe_ready` = 1, next `int_req` granted at +1.
